// File: rtl/nfc_status_poller_pkg.sv
// Shared definitions for the NAND Read Status poller: state encodings,
// status bit positions and the Read Status command identifiers.
package nfc_status_poller_pkg;

  typedef enum logic [6:0] {
    ST_IDLE        = 7'b0000001,
    ST_ISSUE       = 7'b0000010,
    ST_WAIT_STATUS = 7'b0000100,
    ST_WAIT_LAST   = 7'b0001000,
    ST_EVAL        = 7'b0010000,
    ST_GAP         = 7'b0100000,
    ST_DONE        = 7'b1000000
  } poll_state_t;

  localparam int STATUS_RDY_BIT  = 6;
  localparam int STATUS_ARDY_BIT = 5;
  localparam int STATUS_FAIL_BIT = 0;

  localparam logic [7:0] OPC_READ_STATUS     = 8'h70;
  localparam logic [7:0] OPC_READ_STATUS_ENH = 8'h78;

  localparam logic [5:0] READ_STATUS_CMD_ID = 6'b000111;

  // NAND opcode the executor will put on the bus for a given mode.
  function automatic logic [7:0] nand_status_opcode(input logic enhanced);
    return enhanced ? OPC_READ_STATUS_ENH : OPC_READ_STATUS;
  endfunction

  function automatic logic status_array_ready(input logic [7:0] status);
    return status[STATUS_ARDY_BIT];
  endfunction

endpackage

// File: rtl/nfc_poll_gap_timer.sv
// Loadable 16-bit down-counter that paces successive status polls.
module nfc_poll_gap_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_value,
  output logic        zero
);

  logic [15:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= 16'd0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != 16'd0) begin
      count_reg <= count_reg - 16'd1;
    end
  end

  assign zero = (count_reg == 16'd0);

endmodule

// File: rtl/nfc_status_poller.sv
// Repeatedly issues Read Status commands to the executor until the target
// way reports ready or the poll budget is exhausted.
module nfc_status_poller
  import nfc_status_poller_pkg::*;
#(
  parameter int         NumberOfWays = 4,
  parameter logic [5:0] CommandID    = READ_STATUS_CMD_ID,
  parameter logic [4:0] TargetID     = 5'b00101,
  parameter int         PollGap      = 16,
  parameter int         MaxPolls     = 1024
) (
  input  logic                    iSystemClock,
  input  logic                    iReset,
  input  logic                    iPollStart,
  input  logic [NumberOfWays-1:0] iPollWay,
  input  logic [23:0]             iPollRowAddress,
  input  logic                    iPollEnhanced,
  output logic                    oPollReady,
  output logic                    oPollDone,
  output logic                    oPollFail,
  output logic                    oPollTimeout,
  output logic [7:0]              oPollStatus,
  output logic [15:0]             oPollCount,
  output logic [5:0]              oOpcode,
  output logic [4:0]              oTargetID,
  output logic                    oCMDValid,
  input  logic                    iCMDReady,
  output logic [NumberOfWays-1:0] oWaySelect,
  output logic [23:0]             oRowAddress,
  input  logic [23:0]             iStatus,
  input  logic                    iStatusValid,
  input  logic                    iLastStep
);

  localparam logic [15:0] GAP_LOAD  = 16'(PollGap - 1);
  localparam logic [15:0] MAX_POLLS = 16'(MaxPolls);

  poll_state_t state_reg, state_next;

  logic [NumberOfWays-1:0] way_reg;
  logic [23:0]             row_reg;
  logic                    enhanced_reg;
  logic [7:0]              status_reg;
  logic [15:0]             count_reg;
  logic                    fail_reg;
  logic                    timeout_reg;
  logic                    gap_load;
  logic                    gap_zero;
  logic [15:0]             unused_status_hi;

  assign unused_status_hi = iStatus[23:8];

  always_ff @(posedge iSystemClock or posedge iReset) begin
    if (iReset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    gap_load   = 1'b0;
    oPollReady = 1'b0;
    oPollDone  = 1'b0;
    oCMDValid  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        oPollReady = 1'b1;
        if (iPollStart) state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        oCMDValid = 1'b1;
        if (iCMDReady) state_next = ST_WAIT_STATUS;
      end
      ST_WAIT_STATUS: begin
        if (iStatusValid) state_next = iLastStep ? ST_EVAL : ST_WAIT_LAST;
        else if (iLastStep) state_next = ST_EVAL;
      end
      ST_WAIT_LAST: begin
        if (iLastStep) state_next = ST_EVAL;
      end
      ST_EVAL: begin
        if (status_reg[STATUS_RDY_BIT] || (count_reg == MAX_POLLS)) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_GAP;
          gap_load   = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_zero) state_next = ST_ISSUE;
      end
      ST_DONE: begin
        oPollDone  = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge iSystemClock or posedge iReset) begin
    if (iReset) begin
      way_reg      <= '0;
      row_reg      <= 24'd0;
      enhanced_reg <= 1'b0;
      status_reg   <= 8'd0;
      count_reg    <= 16'd0;
      fail_reg     <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (iPollStart) begin
            way_reg      <= iPollWay;
            row_reg      <= iPollRowAddress;
            enhanced_reg <= iPollEnhanced;
            status_reg   <= 8'd0;
            count_reg    <= 16'd0;
            fail_reg     <= 1'b0;
            timeout_reg  <= 1'b0;
          end
        end
        ST_ISSUE: begin
          if (iCMDReady && (count_reg != 16'hFFFF)) count_reg <= count_reg + 16'd1;
        end
        ST_WAIT_STATUS: begin
          // A command that finishes without a status word counts as not ready.
          if (iStatusValid) status_reg <= iStatus[7:0];
          else if (iLastStep) status_reg <= 8'd0;
        end
        ST_EVAL: begin
          if (status_reg[STATUS_RDY_BIT]) fail_reg <= status_reg[STATUS_FAIL_BIT];
          else if (count_reg == MAX_POLLS) timeout_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  nfc_poll_gap_timer u_gap_timer (
    .clk        (iSystemClock),
    .rst        (iReset),
    .load       (gap_load),
    .load_value (GAP_LOAD),
    .zero       (gap_zero)
  );

  assign oOpcode      = CommandID;
  assign oTargetID    = {TargetID[4:1], enhanced_reg};
  assign oWaySelect   = way_reg;
  assign oRowAddress  = row_reg;
  assign oPollStatus  = status_reg;
  assign oPollCount   = count_reg;
  assign oPollFail    = fail_reg;
  assign oPollTimeout = timeout_reg;

endmodule

// File: tb/tb_nfc_status_poller.sv
// Randomized scoreboard bench: an executor model answers commands, a reference
// model predicts each request's outcome, and a monitor checks every completion.
module tb_nfc_status_poller;

  localparam int PG   = 5;
  localparam int MAXP = 4;

  logic        clk = 1'b0;
  logic        iReset;
  logic        iPollStart;
  logic [3:0]  iPollWay;
  logic [23:0] iPollRowAddress;
  logic        iPollEnhanced;
  logic        oPollReady, oPollDone, oPollFail, oPollTimeout;
  logic [7:0]  oPollStatus;
  logic [15:0] oPollCount;
  logic [5:0]  oOpcode;
  logic [4:0]  oTargetID;
  logic        oCMDValid;
  logic        iCMDReady;
  logic [3:0]  oWaySelect;
  logic [23:0] oRowAddress;
  logic [23:0] iStatus;
  logic        iStatusValid;
  logic        iLastStep;

  always #5 clk = ~clk;

  nfc_status_poller #(
    .NumberOfWays (4),
    .PollGap      (PG),
    .MaxPolls     (MAXP)
  ) dut (
    .iSystemClock    (clk),
    .iReset          (iReset),
    .iPollStart      (iPollStart),
    .iPollWay        (iPollWay),
    .iPollRowAddress (iPollRowAddress),
    .iPollEnhanced   (iPollEnhanced),
    .oPollReady      (oPollReady),
    .oPollDone       (oPollDone),
    .oPollFail       (oPollFail),
    .oPollTimeout    (oPollTimeout),
    .oPollStatus     (oPollStatus),
    .oPollCount      (oPollCount),
    .oOpcode         (oOpcode),
    .oTargetID       (oTargetID),
    .oCMDValid       (oCMDValid),
    .iCMDReady       (iCMDReady),
    .oWaySelect      (oWaySelect),
    .oRowAddress     (oRowAddress),
    .iStatus         (iStatus),
    .iStatusValid    (iStatusValid),
    .iLastStep       (iLastStep)
  );

  // mode: 0 status then last step, 1 both together, 2 last step only, 3 status then stall
  typedef struct {
    logic [7:0] st;
    int         mode;
    int         d1;
    int         d2;
  } resp_t;

  typedef struct {
    logic        fail;
    logic        tmo;
    logic [7:0]  st;
    logic [15:0] cnt;
    logic [3:0]  way;
    logic [23:0] row;
    logic [4:0]  tid;
  } exp_t;

  resp_t resp_q[$];
  exp_t  exp_q[$];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int rdy_dly = 0;
  int cmd_count = 0;
  int stall_viol = 0;
  int stab_viol = 0;
  int done_count = 0;
  int last_eval_cyc = 0;
  bit eval_known = 0;
  bit abort_req = 0;
  bit status_given = 0;
  bit prev_valid = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic add_resp(input logic [7:0] st, input int mode, input int d1, input int d2);
    resp_t x;
    x.st = st; x.mode = mode; x.d1 = d1; x.d2 = d2;
    resp_q.push_back(x);
  endtask

  // Outcome of a request: walk the poll answers until RDY or the poll budget runs out.
  function automatic exp_t model(input logic [3:0] way, input logic [23:0] row, input logic enh);
    exp_t e;
    e.way = way; e.row = row; e.tid = {4'b0010, enh};
    e.fail = 0; e.tmo = 0; e.st = 8'h00; e.cnt = 16'd0;
    for (int i = 0; i < resp_q.size(); i++) begin
      e.st  = (resp_q[i].mode == 2) ? 8'h00 : resp_q[i].st;
      e.cnt = 16'(i + 1);
      if (e.st[6]) begin
        e.fail = e.st[0];
        return e;
      end
      if (i + 1 == MAXP) begin
        e.tmo = 1;
        return e;
      end
    end
    return e;
  endfunction

  // Executor model
  initial begin : executor
    resp_t r;
    iCMDReady = 0; iStatusValid = 0; iLastStep = 0; iStatus = 24'd0;
    forever begin
      @(negedge clk);
      if (oCMDValid && !iReset) begin
        for (int k = 0; k < rdy_dly; k++) begin
          @(negedge clk);
          if (!oCMDValid) stall_viol++;
        end
        chk("opcode", 32'(oOpcode), 32'h07);
        iCMDReady = 1;
        @(negedge clk);
        iCMDReady = 0;
        cmd_count++;
        chk("valid_drop", 32'(oCMDValid), 0);
        if (resp_q.size() > 0) r = resp_q.pop_front();
        else begin r.st = 8'h00; r.mode = 2; r.d1 = 0; r.d2 = 0; end
        repeat (r.d1) @(negedge clk);
        if (r.mode == 2) begin
          iStatus = 24'hFFFFFF;
          iLastStep = 1;
          last_eval_cyc = cyc + 1; eval_known = 1;
          @(negedge clk);
          iLastStep = 0;
        end else begin
          iStatus = {16'($urandom), r.st};
          iStatusValid = 1;
          if (r.mode == 1) begin
            iLastStep = 1;
            last_eval_cyc = cyc + 1; eval_known = 1;
          end
          @(negedge clk);
          iStatusValid = 0; iLastStep = 0;
          if (r.mode == 0) begin
            repeat (r.d2) @(negedge clk);
            iLastStep = 1;
            last_eval_cyc = cyc + 1; eval_known = 1;
            @(negedge clk);
            iLastStep = 0;
          end else if (r.mode == 3) begin
            status_given = 1;
            while (!abort_req) @(negedge clk);
          end
        end
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (oCMDValid && !prev_valid && eval_known) begin
      chk("gap_spacing", 32'(cyc - last_eval_cyc), 32'(PG + 1));
      eval_known = 0;
    end
    prev_valid = oCMDValid;
    if (!oPollReady && exp_q.size() > 0) begin
      if (oWaySelect !== exp_q[0].way || oRowAddress !== exp_q[0].row ||
          oTargetID !== exp_q[0].tid) stab_viol++;
    end
    if (oPollDone) begin
      done_count++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(oPollDone), 0);
      end else begin
        e = exp_q.pop_front();
        chk("done_fail", 32'(oPollFail), 32'(e.fail));
        chk("done_timeout", 32'(oPollTimeout), 32'(e.tmo));
        chk("done_status", 32'(oPollStatus), 32'(e.st));
        chk("done_count", 32'(oPollCount), 32'(e.cnt));
        chk("cmd_count", 32'(cmd_count), 32'(e.cnt));
        chk("done_latency", 32'(cyc - last_eval_cyc), 1);
        chk("stable_way_row_tid", 32'(stab_viol), 0);
      end
      stab_viol = 0;
      eval_known = 0;
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!oPollReady && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_req(input logic [3:0] way, input logic [23:0] row, input logic enh, input bit noise);
    exp_t e;
    bit   seen;
    e = model(way, row, enh);
    wait_ready();
    exp_q.push_back(e);
    cmd_count = 0; stall_viol = 0; stab_viol = 0;
    iPollWay = way; iPollRowAddress = row; iPollEnhanced = enh; iPollStart = 1;
    @(negedge clk);
    iPollStart = 0;
    chk("start_ready", 32'(oPollReady), 0);
    chk("start_valid", 32'(oCMDValid), 1);
    seen = 0;
    for (int n = 0; n < 3000 && !seen; n++) begin
      iPollStart = noise && ($urandom_range(0, 3) == 0);
      if (iPollStart) begin
        iPollWay = 4'($urandom); iPollRowAddress = 24'($urandom); iPollEnhanced = 1'($urandom);
      end
      @(negedge clk);
      if (oPollDone) seen = 1;
    end
    iPollStart = 0;
    chk("done_seen", 32'(seen), 1);
    if (!seen) exp_q.delete();
    chk("valid_held_while_stalled", 32'(stall_viol), 0);
    @(negedge clk);
    chk("ready_after_done", 32'(oPollReady), 1);
    chk("done_one_cycle", 32'(oPollDone), 0);
    chk("hold_fail", 32'(oPollFail), 32'(e.fail));
    chk("hold_timeout", 32'(oPollTimeout), 32'(e.tmo));
    chk("hold_status", 32'(oPollStatus), 32'(e.st));
    chk("hold_count", 32'(oPollCount), 32'(e.cnt));
    $display("req way=%b row=%h enh=%0d: polls=%0d fail=%0d timeout=%0d status=%h",
             way, row, enh, e.cnt, e.fail, e.tmo, e.st);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int d0;
    int n;
    iReset = 1; iPollStart = 0; iPollWay = 4'd0; iPollRowAddress = 24'd0; iPollEnhanced = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(oPollReady), 1);
    chk("rst_valid", 32'(oCMDValid), 0);
    chk("rst_done", 32'(oPollDone), 0);
    chk("rst_fail", 32'(oPollFail), 0);
    chk("rst_timeout", 32'(oPollTimeout), 0);
    chk("rst_status", 32'(oPollStatus), 0);
    chk("rst_count", 32'(oPollCount), 0);
    chk("rst_way", 32'(oWaySelect), 0);
    chk("rst_row", 32'(oRowAddress), 0);
    chk("rst_opcode", 32'(oOpcode), 32'h07);
    chk("rst_target", 32'(oTargetID), 32'h04);
    iReset = 0;
    @(negedge clk);

    // Normal mode, ready on first poll
    resp_q.delete(); rdy_dly = 0;
    add_resp(8'hE0, 0, 2, 1);
    run_req(4'b0010, 24'h000000, 0, 0);

    // Enhanced, two not-ready polls then ready with FAIL
    resp_q.delete();
    add_resp(8'h80, 0, 1, 2); add_resp(8'h80, 1, 0, 0); add_resp(8'hC1, 0, 0, 0);
    run_req(4'b0100, 24'h012345, 1, 0);

    // Poll budget exhausted
    resp_q.delete();
    for (int i = 0; i < MAXP; i++) add_resp(8'h00, 0, 1, 1);
    run_req(4'b0001, 24'h00ABCD, 0, 0);

    // Executor stalls the handshake for 20 cycles
    resp_q.delete(); rdy_dly = 20;
    add_resp(8'h40, 0, 0, 0);
    run_req(4'b1000, 24'h777777, 1, 0);
    rdy_dly = 0;

    // Commands ending without status, with start pulses while busy
    resp_q.delete();
    add_resp(8'hFF, 2, 1, 0); add_resp(8'hFF, 2, 0, 0); add_resp(8'h41, 0, 1, 0);
    run_req(4'b0011, 24'h00F00F, 0, 1);

    // Reset while waiting for the last step
    resp_q.delete();
    add_resp(8'h80, 3, 1, 0);
    wait_ready();
    iPollWay = 4'b1000; iPollRowAddress = 24'hABCDEF; iPollEnhanced = 1; iPollStart = 1;
    @(negedge clk);
    iPollStart = 0;
    n = 0;
    while (!status_given && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reached_wait_last", 32'(status_given), 1);
    repeat (2) @(negedge clk);
    d0 = done_count;
    #2;
    iReset = 1;
    #1;
    chk("async_rst_valid", 32'(oCMDValid), 0);
    chk("async_rst_ready", 32'(oPollReady), 1);
    chk("async_rst_count", 32'(oPollCount), 0);
    chk("async_rst_way", 32'(oWaySelect), 0);
    abort_req = 1;
    repeat (3) @(negedge clk);
    iReset = 0; abort_req = 0; status_given = 0;
    repeat (5) @(negedge clk);
    chk("no_done_after_reset", 32'(done_count), 32'(d0));

    resp_q.delete();
    add_resp(8'hC0, 1, 0, 0);
    run_req(4'b0010, 24'h123456, 1, 0);

    // Randomized requests
    for (int r = 0; r < 12; r++) begin
      resp_q.delete();
      for (int i = 0; i < MAXP; i++) begin
        logic [7:0] st;
        st = 8'($urandom);
        if ($urandom_range(0, 2) != 0) st[6] = 1'b0;
        add_resp(st, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3));
      end
      rdy_dly = $urandom_range(0, 3);
      run_req(4'($urandom), 24'($urandom), 1'($urandom), 1'($urandom));
    end

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nfc_status_poller.md
# nfc_status_poller

Initiator-side companion to the Read Status command executor: accepts a single "wait for way ready" request, repeatedly issues Read Status (70h) or Read Status Enhanced (78h) commands over the executor's opcode/valid/ready handshake, and consumes the returned status word. It evaluates the RDY (bit 6) and FAIL (bit 0) bits, pacing polls with a programmable gap, and reports ready, fail or timeout to the upstream controller. It sits between the command dispatcher and the Read Status executor.

## Interface
- NumberOfWays, 4, width of way-select vectors
- CommandID, 6'b000111, opcode driven to the executor
- TargetID, 5'b00101, base target ID; bit 0 replaced by enhanced flag
- PollGap, 16, idle cycles between the end of one poll and the next issue (1..65535)
- MaxPolls, 1024, polls before timeout (1..65535)

- iSystemClock  in  1  single clock
- iReset  in  1  asynchronous, active-high reset
- iPollStart  in  1  request strobe; accepted only when oPollReady=1
- iPollWay  in  NumberOfWays  way to poll
- iPollRowAddress  in  24  row address (used by enhanced mode)
- iPollEnhanced  in  1  1 = use 78h
- oPollReady  out  1  idle, may accept request
- oPollDone  out  1  one-cycle completion pulse
- oPollFail  out  1  FAIL bit of final status, valid with/after oPollDone
- oPollTimeout  out  1  completion was by MaxPolls exhaustion
- oPollStatus  out  8  last status byte received
- oPollCount  out  16  polls issued for the current request
- oOpcode  out  6  to executor
- oTargetID  out  5  {TargetID[4:1], enhanced}
- oCMDValid  out  1  command request
- iCMDReady  in  1  executor ready
- oWaySelect  out  NumberOfWays  latched way
- oRowAddress  out  24  latched row
- iStatus  in  24  executor status word; [7:0] status byte
- iStatusValid  in  1  status strobe
- iLastStep  in  1  executor finished the command

## Operation
- States: IDLE, ISSUE, WAIT_STATUS, WAIT_LAST, EVAL, GAP, DONE.
- IDLE: oPollReady=1. On iPollStart, latch way, row, enhanced; clear count and status; go ISSUE.
- ISSUE: oCMDValid=1 with oOpcode=CommandID. Accept when oCMDValid & iCMDReady at a rising edge. Then deassert next cycle, increment count (saturating at 16'hFFFF), go WAIT_STATUS.
- WAIT_STATUS: on iStatusValid, capture iStatus[7:0] and go WAIT_LAST. If iLastStep arrives first, the status is taken as 8'h00 (not ready) and the block goes to EVAL.
- WAIT_LAST: on iLastStep, go EVAL. iLastStep coincident with iStatusValid in WAIT_STATUS: capture the status, then go EVAL.
- EVAL (1 cycle):
  - status[6]=1 → DONE with fail=status[0], timeout=0.
  - Otherwise, count==MaxPolls → DONE with timeout=1, fail=0.
  - Otherwise → GAP.
- GAP: a 16-bit counter loads PollGap-1 and decrements to 0, then the block goes to ISSUE.
- DONE (1 cycle): oPollDone=1, then IDLE. oPollFail, oPollTimeout, oPollStatus and oPollCount hold until the next accepted request.
- iStatusValid or iLastStep outside WAIT_STATUS/WAIT_LAST is ignored.
- iPollStart while not in IDLE is ignored.

## Timing
- Reset values:
  - oPollReady=1.
  - oCMDValid=0, oPollDone=0, oPollFail=0, oPollTimeout=0.
  - oPollStatus=0, oPollCount=0, oWaySelect=0, oRowAddress=0.
  - oOpcode=CommandID, oTargetID={TargetID[4:1],1'b0}.
- Start accepted at edge N → oPollReady=0 and oCMDValid=1 from N+1.
- Command accepted at edge M → oCMDValid=0 from M+1.
- iLastStep at edge L → EVAL at L+1.
  - If ready: DONE at L+2, oPollDone high during the cycle after L+1, oPollReady=1 the cycle after that.
  - Not ready: next oCMDValid rises PollGap+1 cycles after EVAL.
- oWaySelect, oRowAddress and oTargetID stay stable for the whole request.
- Reset mid-operation: immediate return to IDLE. oCMDValid drops asynchronously and no oPollDone is produced.

## Structure
- Shared package/include holds:
  - state one-hot encodings;
  - NAND status bit indices (RDY=6, ARDY=5, FAIL=0);
  - opcode constants 70h/78h;
  - the Read Status CommandID.
- One sub-module, nfc_poll_gap_timer: loadable 16-bit down-counter with a zero flag. Everything else is inline.

## Test plan
- Normal mode, way 4'b0010. Model returns 8'hE0 on the first poll. Expect:
  - one command, oTargetID=5'b00100;
  - oPollDone with fail=0, timeout=0, count=1, status=8'hE0.
- Enhanced, row 24'h012345. Model returns 8'h80, 8'h80, then 8'hC1. Expect:
  - three commands, oTargetID=5'b00101, oRowAddress held at 24'h012345;
  - fail=1, count=3;
  - consecutive oCMDValid rising edges spaced ≥ PollGap+1 cycles after iLastStep.
- MaxPolls=4, model always returns 8'h00 → exactly 4 commands, then timeout=1, fail=0, count=4.
- iCMDReady held low for 20 cycles → oCMDValid stays high throughout, and exactly one command is accepted when iCMDReady rises.
- iLastStep with no iStatusValid → poll counted with status 8'h00 and re-poll scheduled. iPollStart pulses during a busy request are ignored.
- iReset asserted in WAIT_LAST → oCMDValid=0 and oPollReady=1 immediately, no oPollDone. A new request then completes normally.
